// File: rtl/adder_share_ctrl.sv
// Shares one zero-extended 32+32 -> 40-bit adder between two valid/ready requesters.
// Define ADD_SHARE_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module adder_share_ctrl #(
  parameter int unsigned EXEC_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [39:0]      res_data,
  output logic             res_tag,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  localparam logic [3:0]       CntInit = 4'(EXEC_CYCLES - 1);
  localparam logic [3:0]       CntDec  = 4'd1;
  localparam logic [CNT_W-1:0] DoneInc = CNT_W'(1);

  state_e           r_state;
  logic [3:0]       r_cnt;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic             r_tag;
  logic             r_res_valid;
  logic [39:0]      r_res_data;
  logic             r_res_tag;
  logic [CNT_W-1:0] r_done_cnt;
`ifndef ADD_SHARE_FIXED_PRIO_EN
  logic             r_rr_ptr;
`endif

  logic        w_gnt_vld;
  logic        w_gnt_idx;
  logic [31:0] w_sel_a;
  logic [31:0] w_sel_b;
  logic [39:0] w_sum;

  // Grant is only offered in IDLE; a contended grant follows the pointer (or requester 0).
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = 1'b0;
    if (r_state == StIdle) begin
      unique case (req_valid)
        2'b01: begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = 1'b0;
        end
        2'b10: begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = 1'b1;
        end
        2'b11: begin
          w_gnt_vld = 1'b1;
`ifdef ADD_SHARE_FIXED_PRIO_EN
          w_gnt_idx = 1'b0;
`else
          w_gnt_idx = r_rr_ptr;
`endif
        end
        default: begin
          w_gnt_vld = 1'b0;
        end
      endcase
    end
  end

  assign req_ready = w_gnt_vld ? (w_gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  assign w_sel_a   = w_gnt_idx ? req1_a : req0_a;
  assign w_sel_b   = w_gnt_idx ? req1_b : req0_b;
  assign w_sum     = {8'b0, r_op_a} + {8'b0, r_op_b};

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_op_a      <= 32'd0;
      r_op_b      <= 32'd0;
      r_tag       <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= 40'd0;
      r_res_tag   <= 1'b0;
      r_done_cnt  <= '0;
`ifndef ADD_SHARE_FIXED_PRIO_EN
      r_rr_ptr    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_gnt_vld) begin
            r_op_a  <= w_sel_a;
            r_op_b  <= w_sel_b;
            r_tag   <= w_gnt_idx;
            r_cnt   <= CntInit;
            r_state <= StExec;
`ifndef ADD_SHARE_FIXED_PRIO_EN
            r_rr_ptr <= ~w_gnt_idx;
`endif
          end
        end
        StExec: begin
          if (r_cnt == 4'd0) begin
            r_res_data  <= w_sum;
            r_res_tag   <= r_tag;
            r_res_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_cnt <= r_cnt - CntDec;
          end
        end
        StDone: begin
          // res_data/res_tag are left holding the last result after the handshake.
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + DoneInc;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_tag   = r_res_tag;
  assign done_cnt  = r_done_cnt;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl: a cycle model predicts grants/results, a queue holds them.
module tb_adder_share_ctrl;

  localparam int unsigned EXEC = 2;
  localparam int unsigned CW   = 2;

  logic          clk = 1'b0;
  logic          nRST;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [31:0]   req0_a, req0_b, req1_a, req1_b;
  logic          res_valid;
  logic          res_ready;
  logic [39:0]   res_data;
  logic          res_tag;
  logic          busy;
  logic [CW-1:0] done_cnt;

  adder_share_ctrl #(
    .EXEC_CYCLES(EXEC),
    .CNT_W      (CW)
  ) u_dut (
    .clk      (clk),
    .nRST     (nRST),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req0_a   (req0_a),
    .req0_b   (req0_b),
    .req1_a   (req1_a),
    .req1_b   (req1_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_tag  (res_tag),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [39:0] data;
    logic        tag;
  } exp_t;

  exp_t          sb[$];
  logic          tags_seen[$];
  int            n_chk  = 0;
  int            n_pass = 0;
  int            n_done = 0;
  int            m_phase = 0;
  int            m_cnt = 0;
  logic          m_rr = 1'b0;
  logic [CW-1:0] m_done = '0;
  logic [39:0]   lst_data = '0;
  logic          lst_tag = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model, evaluated on the falling edge; predicts the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    logic have;
    logic g;
    logic [1:0] exp_rdy;
    if (!nRST) begin
      m_phase = 0;
      m_rr    = 1'b0;
      m_done  = '0;
      sb.delete();
      check_eq("rst_res_valid", {63'd0, res_valid}, 64'd0);
      check_eq("rst_busy", {63'd0, busy}, 64'd0);
    end else begin
      check_eq("done_cnt", {62'd0, done_cnt}, {62'd0, m_done});
      check_eq("busy", {63'd0, busy}, {63'd0, m_phase != 0});
      case (m_phase)
        0: begin
          have = 1'b1;
          g    = 1'b0;
          if (req_valid == 2'b11) begin
`ifdef ADD_SHARE_FIXED_PRIO_EN
            g = 1'b0;
`else
            g = m_rr;
`endif
          end else if (req_valid == 2'b10) g = 1'b1;
          else if (req_valid == 2'b01) g = 1'b0;
          else have = 1'b0;
          exp_rdy = have ? (g ? 2'b10 : 2'b01) : 2'b00;
          check_eq("req_ready_idle", {62'd0, req_ready}, {62'd0, exp_rdy});
          check_eq("res_valid_idle", {63'd0, res_valid}, 64'd0);
          if (have) begin
            e.tag  = g;
            e.data = g ? ({8'd0, req1_a} + {8'd0, req1_b}) : ({8'd0, req0_a} + {8'd0, req0_b});
            sb.push_back(e);
            m_rr    = ~g;
            m_cnt   = EXEC - 1;
            m_phase = 1;
          end
        end
        1: begin
          check_eq("req_ready_exec", {62'd0, req_ready}, 64'd0);
          check_eq("res_valid_exec", {63'd0, res_valid}, 64'd0);
          if (m_cnt == 0) m_phase = 2;
          else m_cnt--;
        end
        default: begin
          check_eq("req_ready_done", {62'd0, req_ready}, 64'd0);
          check_eq("res_valid_done", {63'd0, res_valid}, 64'd1);
          if (sb.size() == 0) begin
            check_eq("sb_empty", 64'd1, 64'd0);
          end else begin
            e = sb[0];
            check_eq("res_data", {24'd0, res_data}, {24'd0, e.data});
            check_eq("res_tag", {63'd0, res_tag}, {63'd0, e.tag});
            if (res_ready) begin
              void'(sb.pop_front());
              tags_seen.push_back(e.tag);
              lst_data = e.data;
              lst_tag  = e.tag;
              m_done   = m_done + 1'b1;
              n_done++;
              m_phase  = 0;
            end
          end
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int ph, input int budget);
    int k = 0;
    while (m_phase != ph && k < budget) begin
      step();
      k++;
    end
    if (m_phase != ph) check_eq("timeout_phase", 64'(m_phase), 64'(ph));
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (n_done < n && k < budget) begin
      step();
      k++;
    end
    if (n_done < n) check_eq("timeout_done", 64'(n_done), 64'(n));
  endtask

  initial begin
    int base;
    logic exp_tags[4];
    nRST      = 1'b0;
    req_valid = 2'b00;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    res_ready = 1'b1;
    step();
    step();
    check_eq("init_res_data", {24'd0, res_data}, 64'd0);
    check_eq("init_res_tag", {63'd0, res_tag}, 64'd0);
    check_eq("init_done_cnt", {62'd0, done_cnt}, 64'd0);
    nRST = 1'b1;
    step();

    // Single request from requester 0.
    req0_a = 32'h0000_0010; req0_b = 32'h0000_0020; req_valid = 2'b01;
    wait_phase(1, 20);
    req_valid = 2'b00;
    wait_done(1, 20);
    check_eq("single_data", {24'd0, lst_data}, 64'h30);
    check_eq("single_tag", {63'd0, lst_tag}, 64'd0);
    check_eq("single_done_cnt", {62'd0, done_cnt}, 64'd1);
    check_eq("single_busy", {63'd0, busy}, 64'd0);

    // Max operands from requester 1.
    req1_a = 32'hFFFF_FFFF; req1_b = 32'hFFFF_FFFF; req_valid = 2'b10;
    wait_phase(1, 20);
    req_valid = 2'b00;
    wait_done(2, 20);
    check_eq("max_data", {24'd0, lst_data}, 64'h01_FFFF_FFFE);
    check_eq("max_tag", {63'd0, lst_tag}, 64'd1);

    // Reset in the middle of EXEC discards the operation.
    req0_a = 32'd5; req0_b = 32'd7; req_valid = 2'b01;
    wait_phase(1, 20);
    req_valid = 2'b00;
    step();
    nRST = 1'b0;
    #1;
    check_eq("arst_res_valid", {63'd0, res_valid}, 64'd0);
    check_eq("arst_busy", {63'd0, busy}, 64'd0);
    check_eq("arst_done_cnt", {62'd0, done_cnt}, 64'd0);
    check_eq("arst_res_data", {24'd0, res_data}, 64'd0);
    step();
    nRST = 1'b1;
    base = n_done;
    repeat (8) step();
    check_eq("no_result_after_rst", 64'(n_done), 64'(base));

    // Contention: both requesters held valid for four transactions.
    tags_seen.delete();
    req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
    req_valid = 2'b11;
    wait_done(base + 4, 60);
    req_valid = 2'b00;
`ifdef ADD_SHARE_FIXED_PRIO_EN
    exp_tags = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_tags = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin
      if (i < tags_seen.size()) check_eq($sformatf("contend_tag%0d", i),
                                         {63'd0, tags_seen[i]}, {63'd0, exp_tags[i]});
      else check_eq($sformatf("contend_missing%0d", i), 64'd0, 64'd1);
    end
    check_eq("wrap_done_cnt", {62'd0, done_cnt}, 64'd0);

    // Backpressure in DONE with a pending request from requester 1.
    res_ready = 1'b0;
    req0_a = 32'h0000_1234; req0_b = 32'h0000_4321; req_valid = 2'b01;
    wait_phase(1, 20);
    req1_a = 32'h0000_0100; req1_b = 32'h0000_0001; req_valid = 2'b10;
    wait_phase(2, 20);
    repeat (5) begin
      step();
      check_eq("bp_res_valid", {63'd0, res_valid}, 64'd1);
      check_eq("bp_res_data", {24'd0, res_data}, 64'h5555);
      check_eq("bp_req_ready", {62'd0, req_ready}, 64'd0);
    end
    res_ready = 1'b1;
    step();
    check_eq("bp_accept_ready", {62'd0, req_ready}, 64'h2);
    check_eq("bp_done_cnt", {62'd0, done_cnt}, 64'd1);
    step();
    req_valid = 2'b00;
    wait_done(base + 6, 20);
    check_eq("bp_second_data", {24'd0, lst_data}, 64'h101);
    check_eq("bp_second_tag", {63'd0, lst_tag}, 64'd1);
    check_eq("bp_final_done_cnt", {62'd0, done_cnt}, 64'd2);
    step();
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
